datapath_ctrl: RTL and testbench

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/datapath_ctrl_if.sv | 36 +++
 rtl/datapath_ctrl.sv | 138 +++++++++++++
 tb/tb_datapath_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_if.sv
// datapath_ctrl_if -- bus between a sequencer client and the datapath controller.
//   master : drives s (start), load (IR load enable), in (instruction word);
//            observes w (idle), err (trap flag), sximm8 and all datapath strobes.
//   slave  : the controller side (datapath_ctrl).
interface datapath_ctrl_if #(parameter int DW = 16);
    logic          s;
    logic          load;
    logic [DW-1:0] in;
    logic          w;
    logic          err;
    logic [DW-1:0] sximm8;
    logic          vsel;
    logic          write;
    logic          loada;
    logic          loadb;
    logic          asel;
    logic          bsel;
    logic          loadc;
    logic          loads;
    logic [2:0]    readnum;
    logic [2:0]    writenum;
    logic [1:0]    shift;
    logic [1:0]    ALUop;

    modport master (
        output s, load, in,
        input  w, err, sximm8, vsel, write, loada, loadb, asel, bsel,
               loadc, loads, readnum, writenum, shift, ALUop
    );

    modport slave (
        input  s, load, in,
        output w, err, sximm8, vsel, write, loada, loadb, asel, bsel,
               loadc, loads, readnum, writenum, shift, ALUop
    );
endinterface

// File: rtl/datapath_ctrl.sv
// datapath_ctrl -- instruction register plus sequencing FSM for a simple
// register/ALU datapath (MOV imm, MOV reg, ADD, CMP, AND, MVN).
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : datapath_ctrl_if.slave (s/load/in in; w/err/sximm8/strobes out)
// Optional feature: define ILLEGAL_TRAP_EN to park illegal instructions in
// ERR (err=1, w=0) until reset; otherwise illegal instructions are dropped.
// All outputs are decoded from state and IR only (Moore), so reset clears
// them in the same cycle it is asserted.
module datapath_ctrl #(
    parameter int DW = 16
) (
    input logic           clk,
    input logic           rst_n,
    datapath_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM, ERR
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] ir;

    // IR fields
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    logic is_mov, is_alu, mov_imm, mov_reg, is_cmp, is_mvn;
    assign is_mov  = (opcode == 3'b110);
    assign is_alu  = (opcode == 3'b101);
    assign mov_imm = is_mov && (op == 2'b10);
    assign mov_reg = is_mov && (op == 2'b00);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == WAIT && bus.load)
                ir <= bus.in;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT:    if (bus.s) state_nx = DECODE;
            DECODE: begin
                if (mov_imm)                state_nx = WR_IMM;
                else if (mov_reg || is_mvn) state_nx = GET_B;   // single-operand ops skip GET_A
                else if (is_alu)            state_nx = GET_A;
                else begin
`ifdef ILLEGAL_TRAP_EN
                    state_nx = ERR;
`else
                    state_nx = WAIT;
`endif
                end
            end
            GET_A:   state_nx = GET_B;
            GET_B:   state_nx = ALU;
            ALU:     state_nx = is_cmp ? WAIT : WR_REG;        // CMP only updates status
            WR_REG:  state_nx = WAIT;
            WR_IMM:  state_nx = WAIT;
            ERR: begin
`ifdef ILLEGAL_TRAP_EN
                state_nx = ERR;                                 // sticky until reset
`else
                state_nx = WAIT;
`endif
            end
            default: state_nx = WAIT;
        endcase
    end

    always_comb begin
        bus.w        = (state == WAIT);
`ifdef ILLEGAL_TRAP_EN
        bus.err      = (state == ERR);
`else
        bus.err      = 1'b0;
`endif
        bus.sximm8   = {{(DW-8){ir[7]}}, ir[7:0]};
        bus.vsel     = 1'b0;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.shift    = 2'b00;
        bus.ALUop    = 2'b00;
        case (state)
            GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                bus.shift   = sh;
            end
            ALU: begin
                bus.shift = sh;
                // MOV reg passes the shifted B through an add with A forced to 0
                bus.asel  = mov_reg;
                bus.ALUop = mov_reg ? 2'b00 : op;
                if (is_cmp) bus.loads = 1'b1;
                else        bus.loadc = 1'b1;
            end
            WR_REG: begin
                bus.writenum = rd;
                bus.write    = 1'b1;
            end
            WR_IMM: begin
                bus.vsel     = 1'b1;
                bus.writenum = rn;
                bus.write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl -- self-checking bench for datapath_ctrl: table of known
// instructions with a behavioural register-file datapath, hand sequences for
// load-only, reset mid-instruction and illegal opcodes, then random words
// checked cycle by cycle against a per-instruction expected strobe trace.
module tb_datapath_ctrl;

    logic clk;
    logic rst_n;

    datapath_ctrl_if #(.DW(16)) ifc ();

    datapath_ctrl #(.DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       w, err, vsel, write, loada, loadb, asel, bsel, loadc, loads;
        logic [2:0] readnum, writenum;
        logic [1:0] shift, aluop;
    } ctl_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] ir_m = 16'h0;
    ctl_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctl_t cur();
        ctl_t c;
        c.w = ifc.w; c.err = ifc.err; c.vsel = ifc.vsel; c.write = ifc.write;
        c.loada = ifc.loada; c.loadb = ifc.loadb; c.asel = ifc.asel; c.bsel = ifc.bsel;
        c.loadc = ifc.loadc; c.loads = ifc.loads; c.readnum = ifc.readnum;
        c.writenum = ifc.writenum; c.shift = ifc.shift; c.aluop = ifc.ALUop;
        return c;
    endfunction

    function automatic logic [15:0] sx(input logic [15:0] v);
        return {{8{v[7]}}, v[7:0]};
    endfunction

    function automatic ctl_t idle_v();
        ctl_t c = '0;
        c.w = 1'b1;
        return c;
    endfunction

    function automatic bit legal(input logic [15:0] v);
        return (v[15:13] == 3'b101) || (v[15:13] == 3'b110 && !v[11]);
    endfunction

    // Expected busy-cycle trace: one decode cycle, then the operand fetches,
    // ALU step and write-back each instruction class calls for.
    task automatic build(input logic [15:0] v);
        ctl_t c;
        bit mov, imm, rd_a, rd_b, alu, wr, cmp;
        mov  = (v[15:13] == 3'b110);
        imm  = mov && v[12:11] == 2'b10;
        cmp  = (v[15:11] == 5'b101_01);
        rd_a = (v[15:13] == 3'b101) && v[12:11] != 2'b11;
        rd_b = (v[15:13] == 3'b101) || (mov && v[12:11] == 2'b00);
        alu  = rd_b;
        wr   = rd_b && !cmp;
        exp_q.delete();
        c = '0; exp_q.push_back(c);
        if (imm) begin
            c = '0; c.vsel = 1; c.write = 1; c.writenum = v[10:8]; exp_q.push_back(c);
        end
        if (rd_a) begin
            c = '0; c.loada = 1; c.readnum = v[10:8]; exp_q.push_back(c);
        end
        if (rd_b) begin
            c = '0; c.loadb = 1; c.readnum = v[2:0]; c.shift = v[4:3]; exp_q.push_back(c);
        end
        if (alu) begin
            c = '0; c.shift = v[4:3];
            c.asel  = mov;
            c.aluop = mov ? 2'b00 : v[12:11];
            if (cmp) c.loads = 1; else c.loadc = 1;
            exp_q.push_back(c);
        end
        if (wr) begin
            c = '0; c.write = 1; c.writenum = v[7:5]; exp_q.push_back(c);
        end
    endtask

    // Behavioural datapath driven by the controller's strobes.
    logic [15:0] rf [8];
    logic [15:0] ra, rb, rc, bsh, ain, bin, res;
    always @(posedge clk) begin
        case (ifc.shift)
            2'b00: bsh = rb;
            2'b01: bsh = rb << 1;
            2'b10: bsh = rb >> 1;
            default: bsh = {rb[15], rb[15:1]};
        endcase
        ain = ifc.asel ? 16'h0 : ra;
        bin = ifc.bsel ? ifc.sximm8 : bsh;
        case (ifc.ALUop)
            2'b00: res = ain + bin;
            2'b01: res = ain - bin;
            2'b10: res = ain & bin;
            default: res = ~bin;
        endcase
        if (ifc.loada) ra <= rf[ifc.readnum];
        if (ifc.loadb) rb <= rf[ifc.readnum];
        if (ifc.loadc) rc <= res;
        if (ifc.write) rf[ifc.writenum] <= ifc.vsel ? ifc.sximm8 : rc;
    end

    // Call at a negedge with the DUT in WAIT; returns at the negedge where
    // w is seen high again (bounded), checking every busy cycle on the way.
    task automatic issue(input logic [15:0] word, input bit do_load, input bit hold,
                         output int busy);
        logic [15:0] eff;
        eff = do_load ? word : ir_m;
        build(eff);
        ifc.s = 1'b1; ifc.load = do_load; ifc.in = word;
        ir_m = eff;
        busy = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ifc.s    = hold ? 1'b1 : 1'($urandom & 1);
            ifc.load = 1'($urandom & 1);
            ifc.in   = 16'($urandom);
            if (ifc.w) break;
            if (busy < exp_q.size()) chk("trace", 32'(cur()), 32'(exp_q[busy]));
            chk("sximm8_busy", 32'(ifc.sximm8), 32'(sx(ir_m)));
            busy++;
        end
        ifc.s = 1'b0; ifc.load = 1'b0;
        chk("trace_len", busy, exp_q.size());
        chk("idle_after", 32'(cur()), 32'(idle_v()));
    endtask

    typedef struct {
        logic [15:0] instr;
        int          busy;
        logic [15:0] sximm;
        int          ridx;
        logic [15:0] rval;
    } vec_t;

    vec_t tbl [8];
    int   b;

    initial begin
        tbl[0] = '{16'hD007, 2, 16'h0007, 0, 16'h0007};
        tbl[1] = '{16'hD5FD, 2, 16'hFFFD, 5, 16'hFFFD};
        tbl[2] = '{16'hD102, 2, 16'h0002, 1, 16'h0002};
        tbl[3] = '{16'hA148, 5, 16'h0048, 2, 16'd16};
        tbl[4] = '{16'hC072, 4, 16'h0072, 3, 16'd8};
        tbl[5] = '{16'hB880, 4, 16'hFF80, 4, 16'hFFF8};
        tbl[6] = '{16'hB1A0, 5, 16'hFFA0, 5, 16'h0002};
        tbl[7] = '{16'hA900, 4, 16'h0000, 0, 16'h0007};

        rst_n = 1'b0; ifc.s = 1'b0; ifc.load = 1'b0; ifc.in = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", 32'(cur()), 32'(idle_v()));
        chk("reset_sximm8", 32'(ifc.sximm8), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].instr, 1'b1, (i % 2) == 1, b);
            chk("tbl_busy", b, tbl[i].busy);
            chk("tbl_sximm8", 32'(ifc.sximm8), 32'(tbl[i].sximm));
            chk("tbl_reg", 32'(rf[tbl[i].ridx]), 32'(tbl[i].rval));
        end

        // rerun the held IR (CMP) without reloading
        issue(16'h0, 1'b0, 1'b1, b);
        chk("rerun_busy", b, 4);
        chk("rerun_r0", 32'(rf[0]), 32'h7);

        // load without start: IR updates, stays idle
        ifc.load = 1'b1; ifc.in = 16'h00AB;
        @(negedge clk);
        ifc.load = 1'b0;
        ir_m = 16'h00AB;
        chk("load_only_sx", 32'(ifc.sximm8), 32'hFFAB);
        @(negedge clk);
        chk("load_only_idle", 32'(cur()), 32'(idle_v()));

        // reset during GET_B of MVN R3,R0
        ifc.s = 1'b1; ifc.load = 1'b1; ifc.in = 16'hB878;
        @(negedge clk);
        ifc.s = 1'b0; ifc.load = 1'b0;
        @(negedge clk);
        chk("pre_rst_loadb", 32'(ifc.loadb), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 32'(cur()), 32'(idle_v()));
        chk("rst_mid_sx", 32'(ifc.sximm8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ir_m = 16'h0;
        @(negedge clk);
        chk("rst_mid_idle", 32'(cur()), 32'(idle_v()));
        chk("rst_mid_r3", 32'(rf[3]), 32'h8);

`ifdef ILLEGAL_TRAP_EN
        ifc.s = 1'b1; ifc.load = 1'b1; ifc.in = 16'h0000;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            ctl_t e;
            ifc.s = 1'($urandom & 1); ifc.load = 1'($urandom & 1); ifc.in = 16'($urandom);
            @(negedge clk);
            e = '0; e.err = 1'b1;
            chk("trap_hold", 32'(cur()), 32'(e));
            chk("trap_sx", 32'(ifc.sximm8), 32'h0);
        end
        ifc.s = 1'b0; ifc.load = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk("trap_reset", 32'(cur()), 32'(idle_v()));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`else
        issue(16'h0000, 1'b1, 1'b0, b);
        chk("illegal_000_busy", b, 1);
        issue(16'hC800, 1'b1, 1'b0, b);
        chk("illegal_mov01_busy", b, 1);
        issue(16'hFDAA, 1'b1, 1'b1, b);
        chk("illegal_111_busy", b, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (($urandom & 3) != 0) v[15:13] = ($urandom & 1) ? 3'b101 : 3'b110;
`ifdef ILLEGAL_TRAP_EN
            if (!legal(v)) v[15:13] = 3'b101;
`endif
            issue(v, 1'b1, 1'($urandom & 1), b);
            chk("rand_sximm8", 32'(ifc.sximm8), 32'(sx(v)));
            if (!legal(v)) chk("rand_illegal_busy", b, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
